regfile_scoreboard: RTL and testbench

//  Parametrised successor of the RV32IM pipeline register file, used in the ID stage.
//  - Configurable data width, depth and read-port count.
//  - Hardwired-zero register x0 and same-cycle write-to-read bypass.
//  - Per-register busy scoreboard: marked when a long-latency producer (load/mul/div)

---
 rtl/regfile_if.sv | 28 ++
 rtl/regfile_scoreboard.sv | 93 +++++++++
 tb/tb_regfile_scoreboard.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Register-file bus: write port, packed read ports, scoreboard mark/flush and status.
// The master side is the ID/WB pipeline logic; the slave side is the register file.
interface regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) ();
   logic                     writeenable;
   logic [ADDR_W-1:0]        reg_write;
   logic [DATA_W-1:0]        write_data;
   logic [NUM_RD*ADDR_W-1:0] read_addr;
   logic [NUM_RD*DATA_W-1:0] read_data;
   logic [NUM_RD-1:0]        read_busy;
   logic                     mark_en;
   logic [ADDR_W-1:0]        mark_addr;
   logic                     flush;
   logic [ADDR_W:0]          busy_count;

   modport master (
      output writeenable, reg_write, write_data, read_addr, mark_en, mark_addr, flush,
      input  read_data, read_busy, busy_count
   );

   modport slave (
      input  writeenable, reg_write, write_data, read_addr, mark_en, mark_addr, flush,
      output read_data, read_busy, busy_count
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired x0, write-to-read bypass and a
// per-register busy scoreboard for long-latency producers.
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic     clk,
   input logic     rst,
   regfile_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        mem_reg [DEPTH];
   logic [DEPTH-1:0]         busy_reg;
   logic [DEPTH-1:0]         busy_next;
   logic [ADDR_W:0]          busy_count_reg;
   logic [ADDR_W:0]          busy_count_next;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [ADDR_W-1:0]        rd_addr;
   logic                     wr_ok;
   logic                     mark_ok;

   // x0 swallows both writes and marks when hardwired to zero
   assign wr_ok   = bus.writeenable && !((ZERO_REG != 0) && (bus.reg_write == '0));
   assign mark_ok = bus.mark_en && !((ZERO_REG != 0) && (bus.mark_addr == '0));

   // Register storage; cleared wholesale on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      end else if (wr_ok) begin
         mem_reg[bus.reg_write] <= bus.write_data;
      end
   end

   // Busy update: flush beats everything, then a new mark beats the write-back clear
   always_comb begin
      busy_next = busy_reg;
      if (bus.flush) begin
         busy_next = '0;
      end else begin
         if (wr_ok)   busy_next[bus.reg_write] = 1'b0;
         if (mark_ok) busy_next[bus.mark_addr] = 1'b1;
      end
   end

   // Popcount of the next busy vector so the registered count tracks busy exactly
   always_comb begin
      busy_count_next = '0;
      for (int i = 0; i < DEPTH; i++)
         busy_count_next = busy_count_next + {{ADDR_W{1'b0}}, busy_next[i]};
   end

   // Scoreboard state and its population count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_reg       <= '0;
         busy_count_reg <= '0;
      end else begin
         busy_reg       <= busy_next;
         busy_count_reg <= busy_count_next;
      end
   end

   // Combinational read ports with x0 forcing and same-cycle write forwarding
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      rd_addr = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_addr = bus.read_addr[k*ADDR_W +: ADDR_W];
         if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data[k*DATA_W +: DATA_W] = '0;
            rd_busy[k]                  = 1'b0;
         end else if ((BYPASS != 0) && wr_ok && (bus.reg_write == rd_addr)) begin
            rd_data[k*DATA_W +: DATA_W] = bus.write_data;
            // the retiring write resolves the hazard unless a new producer claims it now
            rd_busy[k] = (mark_ok && (bus.mark_addr == rd_addr)) ? busy_reg[rd_addr] : 1'b0;
         end else begin
            rd_data[k*DATA_W +: DATA_W] = mem_reg[rd_addr];
            rd_busy[k]                  = busy_reg[rd_addr];
         end
      end
   end

   assign bus.read_data  = rd_data;
   assign bus.read_busy  = rd_busy;
   assign bus.busy_count = busy_count_reg;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + random bench for regfile_scoreboard (3 read ports, x0 hardwired, bypass on).
module tb_regfile_scoreboard;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] data [NR];
      logic [NR-1:0] busy;
      logic [AW:0] count;
   } exp_t;

   exp_t        sb [$];
   int          tests = 0;
   int          fails = 0;

   // reference model state
   logic [31:0] m_mem [32];
   logic [31:0] m_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0;
   endtask

   // expected outputs in the current cycle, built from the model and the driven inputs
   task automatic push_expect(input string tag);
      exp_t e;
      logic [4:0] a;
      e.tag   = tag;
      e.busy  = '0;
      e.count = 6'($countones(m_busy));
      for (int k = 0; k < NR; k++) begin
         a = bus.read_addr[k*AW +: AW];
         if (a == 5'd0) begin
            e.data[k] = 32'd0;
         end else if (bus.writeenable && bus.reg_write == a) begin
            e.data[k] = bus.write_data;
            e.busy[k] = (bus.mark_en && bus.mark_addr == a) ? m_busy[a] : 1'b0;
         end else begin
            e.data[k] = m_mem[a];
            e.busy[k] = m_busy[a];
         end
      end
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         for (int k = 0; k < NR; k++)
            check($sformatf("%s.data%0d", e.tag, k), bus.read_data[k*DW +: DW], e.data[k]);
         check({e.tag, ".busy"},  {29'd0, bus.read_busy}, {29'd0, e.busy});
         check({e.tag, ".count"}, {26'd0, bus.busy_count}, {26'd0, e.count});
         $display("[TB] %s rd=%h/%h/%h busy=%b count=%0d", e.tag,
                  bus.read_data[0 +: DW], bus.read_data[DW +: DW], bus.read_data[2*DW +: DW],
                  bus.read_busy, bus.busy_count);
      end
   endtask

   // model state update at the edge, following the scoreboard priority list
   task automatic model_edge();
      logic [31:0] nb;
      for (int i = 0; i < 32; i++) begin
         if (bus.flush)                                          nb[i] = 1'b0;
         else if (bus.mark_en && bus.mark_addr == 5'(i) && i != 0) nb[i] = 1'b1;
         else if (bus.writeenable && bus.reg_write == 5'(i))     nb[i] = 1'b0;
         else                                                    nb[i] = m_busy[i];
      end
      if (bus.writeenable && bus.reg_write != 5'd0) m_mem[bus.reg_write] = bus.write_data;
      m_busy = nb;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic me, input logic [4:0] ma, input logic fl);
      bus.writeenable = we;
      bus.reg_write   = wa;
      bus.write_data  = wd;
      bus.read_addr   = {r2, r1, r0};
      bus.mark_en     = me;
      bus.mark_addr   = ma;
      bus.flush       = fl;
   endtask

   task automatic step(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                       input logic me, input logic [4:0] ma, input logic fl);
      @(negedge clk);
      drive(we, wa, wd, r0, r1, r2, me, ma, fl);
      push_expect(tag);
      #1;
      pop_check();
      model_edge();
   endtask

   initial begin
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 1: reset state on every address
      for (int a = 0; a < 32; a += 3)
         step("reset_read", 0, 0, 0, 5'(a), 5'((a + 1) % 32), 5'((a + 2) % 32), 0, 0, 0);

      // 2: same-cycle bypass then stored value
      step("bypass_x5", 1, 5, 32'hDEADBEEF, 5, 6, 0, 0, 0, 0);
      step("stored_x5", 0, 0, 0, 5, 5, 5, 0, 0, 0);
      check("x5_const", bus.read_data[0 +: DW], 32'hDEADBEEF);

      // 3: x0 is hardwired
      step("write_x0", 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
      step("read_x0", 0, 0, 0, 0, 5, 0, 1, 0, 0);
      step("mark_x0_cnt", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("x0_count_const", {26'd0, bus.busy_count}, 32'd0);

      // 4: mark, observe busy, clear by write-back with bypass
      step("mark_x7", 0, 0, 0, 7, 0, 0, 1, 7, 0);
      step("busy_x7", 0, 0, 0, 7, 7, 0, 0, 0, 0);
      check("x7_busy_const", {31'd0, bus.read_busy[0]}, 32'd1);
      step("wb_x7", 1, 7, 32'd9, 7, 0, 0, 0, 0, 0);
      check("x7_bypass_busy_const", {31'd0, bus.read_busy[0]}, 32'd0);
      step("after_wb_x7", 0, 0, 0, 7, 0, 0, 0, 0, 0);

      // 5: mark+write same reg, flush with mark, mark/clear of different regs
      step("mark_wr_x3", 1, 3, 32'h33, 3, 0, 0, 1, 3, 0);
      step("busy_x3", 0, 0, 0, 3, 4, 0, 0, 0, 0);
      step("mark_x10", 0, 0, 0, 10, 0, 0, 1, 10, 0);
      step("mark11_wb10", 1, 10, 32'hA, 10, 11, 3, 1, 11, 0);
      step("net_zero", 0, 0, 0, 10, 11, 3, 0, 0, 0);
      step("flush_mark4", 1, 12, 32'hC0DE, 3, 4, 12, 1, 4, 1);
      step("after_flush", 0, 0, 0, 3, 4, 12, 0, 0, 0);
      check("flush_count_const", {26'd0, bus.busy_count}, 32'd0);

      // 6: asynchronous reset between edges
      step("mark_x1", 1, 1, 32'h11, 1, 2, 3, 1, 1, 0);
      step("mark_x2", 1, 2, 32'h22, 1, 2, 3, 1, 2, 0);
      step("mark_x3", 0, 0, 0, 1, 2, 3, 1, 3, 0);
      @(negedge clk);
      drive(0, 0, 0, 1, 2, 3, 0, 0, 0);
      push_expect("pre_async_rst");
      #1;
      pop_check();
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      push_expect("async_rst");
      pop_check();
      @(negedge clk);
      rst = 1'b1;
      step("first_after_rst", 1, 1, 32'h5A5A, 1, 0, 0, 1, 2, 0);
      step("post_rst_read", 0, 0, 0, 1, 2, 3, 0, 0, 0);

      // 7: random traffic against the model
      for (int n = 0; n < 300; n++) begin
         step("rand",
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
